// File: rtl/fetch_icache_pkg.sv
// Shared state type, bus widths and address-field helpers for the fetch-side instruction cache.
package fetch_icache_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESP
    } cacheState_t;

    // Fields are returned full-width; callers narrow them to the field width they need.
    function automatic logic [ADDR_W-1:0] addrTag(input logic [ADDR_W-1:0] addr,
                                                  input int idxW, input int offW);
        return addr >> (idxW + offW);
    endfunction

    function automatic logic [ADDR_W-1:0] addrIndex(input logic [ADDR_W-1:0] addr,
                                                    input int idxW, input int offW);
        return (addr >> offW) & ADDR_W'((1 << idxW) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] addrOffset(input logic [ADDR_W-1:0] addr,
                                                     input int offW);
        return addr & ADDR_W'((1 << offW) - 1);
    endfunction

    function automatic logic [ADDR_W-1:0] addrLineBase(input logic [ADDR_W-1:0] addr,
                                                       input int offW);
        return addr & ~ADDR_W'((1 << offW) - 1);
    endfunction

endpackage

// File: rtl/fetch_icache_array.sv
// Direct-mapped storage: word-addressable data lines, per-line tags and a valid vector.
module fetch_icache_array
    import fetch_icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int TAG_W      = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rdIndex,
    input  logic [OFF_W-1:0]  rdOffset,
    input  logic [TAG_W-1:0]  rdTag,
    output logic [DATA_W-1:0] rdData,
    output logic              hit,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrIndex,
    input  logic [OFF_W-1:0]  wrOffset,
    input  logic [DATA_W-1:0] wrData,
    input  logic              tagWrEn,
    input  logic [IDX_W-1:0]  tagWrIndex,
    input  logic [TAG_W-1:0]  tagWrData,
    input  logic              clearAll
);

    logic [DATA_W-1:0]    dataMem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tagMem  [NUM_LINES];
    logic [NUM_LINES-1:0] validQ;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            dataMem[{wrIndex, wrOffset}] <= wrData;
        end
        if (tagWrEn) begin
            tagMem[tagWrIndex] <= tagWrData;
        end
    end

    // A line install in the same cycle as a global clear survives the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            validQ <= '0;
        end else begin
            if (clearAll) begin
                validQ <= '0;
            end
            if (tagWrEn) begin
                validQ[tagWrIndex] <= 1'b1;
            end
        end
    end

    assign rdData = dataMem[{rdIndex, rdOffset}];
    assign hit    = validQ[rdIndex] && (tagMem[rdIndex] == rdTag);

endmodule

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache between the fetch stage and a req/ack main-memory word bus.
module fetch_icache
    import fetch_icache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ReqValid,
    input  logic [ADDR_W-1:0] ReqAddr,
    output logic              ReqReady,
    output logic              RespValid,
    output logic [DATA_W-1:0] RespInstruct,
    input  logic              Flush,
    input  logic              Invalidate,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemData
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    cacheState_t stateQ, stateNext;

    logic [ADDR_W-1:0] reqAddrQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic              memReqQ;
    logic              killQ;
    logic              pendInvQ;
    logic [DATA_W-1:0] lastInstrQ;

    logic [TAG_W-1:0]  reqTag;
    logic [IDX_W-1:0]  reqIdx;
    logic [OFF_W-1:0]  reqOff;
    logic [TAG_W-1:0]  memTag;
    logic [IDX_W-1:0]  memIdx;
    logic [OFF_W-1:0]  memOff;

    logic              arrayHit;
    logic [DATA_W-1:0] rdData;
    logic              accept;
    logic              fillAck;
    logic              lastAck;
    logic              respValid;
    logic              clearAll;

    assign reqTag = TAG_W'(addrTag(reqAddrQ, IDX_W, OFF_W));
    assign reqIdx = IDX_W'(addrIndex(reqAddrQ, IDX_W, OFF_W));
    assign reqOff = OFF_W'(addrOffset(reqAddrQ, OFF_W));
    assign memTag = TAG_W'(addrTag(memAddrQ, IDX_W, OFF_W));
    assign memIdx = IDX_W'(addrIndex(memAddrQ, IDX_W, OFF_W));
    assign memOff = OFF_W'(addrOffset(memAddrQ, OFF_W));

    assign accept  = ReqValid && ReqReady;
    assign fillAck = (stateQ == FILL) && memReqQ && MemAck;
    assign lastAck = fillAck && (memOff == OFF_W'(LINE_WORDS - 1));

    fetch_icache_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .OFF_W      (OFF_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rdIndex    (reqIdx),
        .rdOffset   (reqOff),
        .rdTag      (reqTag),
        .rdData     (rdData),
        .hit        (arrayHit),
        .wrEn       (fillAck),
        .wrIndex    (memIdx),
        .wrOffset   (memOff),
        .wrData     (MemData),
        .tagWrEn    (lastAck),
        .tagWrIndex (memIdx),
        .tagWrData  (memTag),
        .clearAll   (clearAll)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (accept) begin
                    stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!arrayHit) begin
                    stateNext = FILL;
                end else if (!accept) begin
                    stateNext = IDLE;
                end
            end
            FILL: begin
                if (lastAck) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Flush kills the response in the cycle it arrives as well as any later one for the same request.
    always_comb begin
        ReqReady  = 1'b0;
        respValid = 1'b0;
        clearAll  = 1'b0;
        unique case (stateQ)
            IDLE: begin
                ReqReady = 1'b1;
                clearAll = Invalidate;
            end
            LOOKUP: begin
                ReqReady  = arrayHit;
                respValid = arrayHit && !(killQ || Flush);
                clearAll  = Invalidate;
            end
            FILL: begin
            end
            RESP: begin
                respValid = !(killQ || Flush);
                clearAll  = pendInvQ || Invalidate;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reqAddrQ   <= '0;
            memReqQ    <= 1'b0;
            memAddrQ   <= '0;
            killQ      <= 1'b0;
            pendInvQ   <= 1'b0;
            lastInstrQ <= '0;
        end else begin
            if (accept) begin
                reqAddrQ <= ReqAddr;
                killQ    <= 1'b0;
            end else if (Flush) begin
                killQ <= 1'b1;
            end

            if (stateQ == LOOKUP && !arrayHit) begin
                memReqQ  <= 1'b1;
                memAddrQ <= addrLineBase(reqAddrQ, OFF_W);
            end else if (fillAck) begin
                if (lastAck) begin
                    memReqQ <= 1'b0;
                end else begin
                    memAddrQ <= memAddrQ + 16'd1;
                end
            end

            // Invalidates seen mid-fill are deferred until the line is installed and answered.
            if (stateQ == RESP) begin
                pendInvQ <= 1'b0;
            end else if (stateQ == FILL && Invalidate) begin
                pendInvQ <= 1'b1;
            end

            if (respValid) begin
                lastInstrQ <= rdData;
            end
        end
    end

    assign RespValid    = respValid;
    assign RespInstruct = respValid ? rdData : lastInstrQ;
    assign MemReq       = memReqQ;
    assign MemAddr      = memAddrQ;

endmodule

// File: tb/tb_fetch_icache.sv
// Randomized self-checking bench for fetch_icache against a line-residency reference model.
module tb_fetch_icache;

    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 16;

    logic        clk;
    logic        rst;
    logic        ReqValid;
    logic [15:0] ReqAddr;
    logic        ReqReady;
    logic        RespValid;
    logic [15:0] RespInstruct;
    logic        Flush;
    logic        Invalidate;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [15:0] MemData;

    int          compareCount;
    int          mismatchCount;
    int          ackWait;
    logic [15:0] mainMem [65536];
    logic [15:0] ackLog [$];
    int          modelLine [NUM_LINES];
    logic [15:0] lastResp;

    fetch_icache #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ReqValid     (ReqValid),
        .ReqAddr      (ReqAddr),
        .ReqReady     (ReqReady),
        .RespValid    (RespValid),
        .RespInstruct (RespInstruct),
        .Flush        (Flush),
        .Invalidate   (Invalidate),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: each word takes ackWait idle cycles, then one ack cycle.
    initial begin
        int waitCnt;
        waitCnt = 0;
        MemAck  = 1'b0;
        MemData = '0;
        forever begin
            @(negedge clk);
            if (MemReq && rst) begin
                if (waitCnt < ackWait) begin
                    MemAck  = 1'b0;
                    waitCnt = waitCnt + 1;
                end else begin
                    MemAck  = 1'b1;
                    MemData = mainMem[MemAddr];
                    ackLog.push_back(MemAddr);
                    waitCnt = 0;
                end
            end else begin
                MemAck  = 1'b0;
                waitCnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount = compareCount + 1;
        if (observed !== expected) begin
            mismatchCount = mismatchCount + 1;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_LINES; i++) begin
            modelLine[i] = -1;
        end
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ReqReady && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput({tag, ".idleReady"}, 32'(ReqReady), 32'd1);
    endtask

    // One request; flushCyc/invCyc give the cycle (0 = request cycle) a one-cycle pulse is applied, -1 none, -2 random flush.
    task automatic applyStimulus(input logic [15:0] addr, input int flushCyc, input int invCyc, input string tag);
        int  a, base, idx, respCyc, stray;
        bit  expHit, killed;
        a    = int'(addr);
        base = a - (a % LINE_WORDS);
        idx  = (a / LINE_WORDS) % NUM_LINES;
        if (invCyc == 0) clearModel();
        expHit  = (modelLine[idx] == base);
        respCyc = expHit ? 1 : LINE_WORDS * (ackWait + 1) + 2;
        if (expHit && invCyc > 1) invCyc = 1;
        if (!expHit && invCyc > respCyc) invCyc = respCyc;
        if (flushCyc == -2) begin
            flushCyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, expHit ? 1 : respCyc - 1)) : -1;
        end
        killed = (flushCyc >= 1) && (flushCyc <= respCyc);

        waitReady(tag);
        ackLog.delete();
        @(posedge clk); #1;
        ReqValid   = 1'b1;
        ReqAddr    = addr;
        Flush      = (flushCyc == 0);
        Invalidate = (invCyc == 0);
        @(negedge clk);
        checkOutput({tag, ".accept"}, 32'(ReqReady), 32'd1);
        stray = 0;
        for (int cyc = 1; cyc <= respCyc + 1; cyc++) begin
            @(posedge clk); #1;
            ReqValid   = 1'b0;
            Flush      = (cyc == flushCyc);
            Invalidate = (cyc == invCyc);
            @(negedge clk);
            if (cyc == 1) checkOutput({tag, ".hitReady"}, 32'(ReqReady), 32'(expHit));
            if (cyc == 2 && !expHit) begin
                checkOutput({tag, ".memReq"}, 32'(MemReq), 32'd1);
                checkOutput({tag, ".memAddrFirst"}, 32'(MemAddr), 32'(base));
            end
            if (cyc == respCyc) begin
                checkOutput({tag, ".respValid"}, 32'(RespValid), 32'(!killed));
                if (!killed) begin
                    checkOutput({tag, ".data"}, 32'(RespInstruct), 32'(mainMem[addr]));
                    lastResp = mainMem[addr];
                end
                if (!expHit) checkOutput({tag, ".memAddrLast"}, 32'(MemAddr), 32'(base + LINE_WORDS - 1));
            end else if (RespValid) begin
                stray = stray + 1;
            end
            if (cyc == respCyc + 1) begin
                checkOutput({tag, ".readyAfter"}, 32'(ReqReady), 32'd1);
                checkOutput({tag, ".memReqAfter"}, 32'(MemReq), 32'd0);
                checkOutput({tag, ".hold"}, 32'(RespInstruct), 32'(lastResp));
            end
        end
        Flush      = 1'b0;
        Invalidate = 1'b0;
        checkOutput({tag, ".strayResp"}, 32'(stray), 32'd0);
        if (!expHit) begin
            checkOutput({tag, ".ackCount"}, 32'(ackLog.size()), 32'(LINE_WORDS));
            for (int i = 0; i < LINE_WORDS && i < ackLog.size(); i++) begin
                checkOutput({tag, ".fillAddr"}, 32'(ackLog[i]), 32'(base + i));
            end
            if (invCyc == 1) clearModel();
            modelLine[idx] = base;
            if (invCyc >= 2) clearModel();
        end else if (invCyc == 1) begin
            clearModel();
        end
    endtask

    // Three back-to-back requests to lines the model says are resident.
    task automatic applyStream(input logic [15:0] addrs [3], input string tag);
        int memReqSeen;
        memReqSeen = 0;
        waitReady(tag);
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            ReqValid = (i < 3);
            if (i < 3) ReqAddr = addrs[i];
            @(negedge clk);
            if (MemReq) memReqSeen = memReqSeen + 1;
            if (i < 3) checkOutput({tag, ".ready"}, 32'(ReqReady), 32'd1);
            if (i >= 1 && i <= 3) begin
                checkOutput({tag, ".respValid"}, 32'(RespValid), 32'd1);
                checkOutput({tag, ".data"}, 32'(RespInstruct), 32'(mainMem[addrs[i-1]]));
                lastResp = mainMem[addrs[i-1]];
            end
            if (i == 4) begin
                checkOutput({tag, ".idleResp"}, 32'(RespValid), 32'd0);
                checkOutput({tag, ".hold"}, 32'(RespInstruct), 32'(lastResp));
            end
        end
        checkOutput({tag, ".memReqIdle"}, 32'(memReqSeen), 32'd0);
    endtask

    task automatic applyResetMidFill(input logic [15:0] addr, input string tag);
        ackWait = 0;
        waitReady(tag);
        @(posedge clk); #1;
        ReqValid = 1'b1;
        ReqAddr  = addr;
        @(negedge clk);
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, ".filling"}, 32'(MemReq), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".memReqDropped"}, 32'(MemReq), 32'd0);
        checkOutput({tag, ".noResp"}, 32'(RespValid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, ".readyAfter"}, 32'(ReqReady), 32'd1);
        checkOutput({tag, ".instrCleared"}, 32'(RespInstruct), 32'd0);
        clearModel();
        lastResp = '0;
    endtask

    function automatic logic [15:0] randAddr();
        int tagSel [4];
        tagSel = '{0, 1, 2, 1023};
        return 16'((tagSel[$urandom_range(0, 3)] << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        logic [15:0] sa [3];
        int          resident [$];
        int          invCyc;
        compareCount  = 0;
        mismatchCount = 0;
        rst        = 1'b0;
        ReqValid   = 1'b0;
        ReqAddr    = '0;
        Flush      = 1'b0;
        Invalidate = 1'b0;
        ackWait    = 0;
        for (int i = 0; i < 65536; i++) mainMem[i] = 16'($urandom);
        for (int i = 4; i < 8; i++) mainMem[i] = 16'hA000 | 16'(i);
        clearModel();
        lastResp = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.respValid", 32'(RespValid), 32'd0);
        checkOutput("reset.respInstruct", 32'(RespInstruct), 32'd0);
        checkOutput("reset.memReq", 32'(MemReq), 32'd0);
        checkOutput("reset.memAddr", 32'(MemAddr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset.ready", 32'(ReqReady), 32'd1);

        $display("[TB] cold miss, hit streaming, conflict miss");
        applyStimulus(16'h0005, -1, -1, "coldMiss");
        sa = '{16'h0004, 16'h0006, 16'h0007};
        applyStream(sa, "hitStream");
        applyStimulus(16'h0045, -1, -1, "conflict");
        applyStimulus(16'h0005, -1, -1, "conflictBack");

        $display("[TB] flush and invalidate cases");
        applyStimulus(16'h0100, 3, -1, "flushFill");
        applyStimulus(16'h0101, -1, -1, "flushHit");
        applyStimulus(16'h0200, -1, 4, "invFill");
        applyStimulus(16'h0201, -1, -1, "invFilledLine");
        applyStimulus(16'h0004, -1, -1, "invOtherLine");
        applyStimulus(16'h0006, 0, -1, "redirectTarget");
        applyStimulus(16'hFFFE, -1, -1, "wrap");

        $display("[TB] reset during fill");
        applyResetMidFill(16'h0300, "resetFill");
        applyStimulus(16'h0300, -1, -1, "resetRefetch");

        $display("[TB] randomized traffic");
        for (int t = 0; t < 80; t++) begin
            ackWait = int'($urandom_range(0, 2));
            resident.delete();
            for (int i = 0; i < NUM_LINES; i++) begin
                if (modelLine[i] != -1) resident.push_back(modelLine[i]);
            end
            if ($urandom_range(0, 5) == 0 && resident.size() > 0) begin
                for (int k = 0; k < 3; k++) begin
                    sa[k] = 16'(resident[$urandom_range(0, resident.size() - 1)] + int'($urandom_range(0, 3)));
                end
                applyStream(sa, "randStream");
            end else begin
                invCyc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 14)) : -1;
                applyStimulus(randAddr(), -2, invCyc, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/fetch_icache.md
Name: fetch_icache

Overview:
Direct-mapped instruction cache on the memory side of the fetch stage. It answers word-addressed fetch requests from the fetch stage and refills lines from slower main memory over a req/ack word bus. It exports ReqReady so the fetch stage can derive its Stall. Flush suppresses a stale response after a branch or jump redirect.

Parameters:
LINE_WORDS, 4, 16-bit words per line (power of 2, at least 2); OFF_W = log2(LINE_WORDS)
NUM_LINES, 16, number of lines (power of 2); IDX_W = log2(NUM_LINES); TAG_W = 16 - IDX_W - OFF_W

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
ReqValid  in  1  fetch request present
ReqAddr  in  16  word address of the instruction
ReqReady  out  1  request accepted this cycle if ReqValid is also high
RespValid  out  1  RespInstruct valid, one-cycle pulse
RespInstruct  out  16  instruction word
Flush  in  1  redirect; kills the response of any already-accepted request
Invalidate  in  1  clear all line valid bits
MemReq  out  1  main-memory word read request
MemAddr  out  16  main-memory word address
MemAck  in  1  MemData valid; completes the current word
MemData  in  16  returned word

Behaviour:
- Address split: tag = ReqAddr[15:IDX_W+OFF_W], index = next IDX_W bits, offset = low OFF_W bits.
- Reset (rst low at an edge):
  - state IDLE; all valid bits 0; pending flags 0.
  - RespValid = 0, RespInstruct = 0, MemReq = 0, MemAddr = 0.
  - ReqReady = 1 from the first cycle after release.
  - A fill in progress is abandoned: MemReq low after that edge, line not installed.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - ReqReady = 1.
  - ReqValid registers the address and moves to LOOKUP.
- LOOKUP (registered address):
  - Hit (valid bit set and tag equal): RespValid = 1 and RespInstruct = word this cycle, so hit latency is 1 cycle after acceptance.
  - On a hit, ReqReady = 1: a back-to-back request is accepted and stays in LOOKUP, otherwise the block returns to IDLE. Sustained hit throughput is 1 per cycle.
  - Miss: ReqReady = 0. MemAddr = {tag, index, OFF_W'b0}, MemReq = 1, go to FILL.
- FILL:
  - MemReq and MemAddr are held stable until MemAck.
  - On each MemAck, MemData is written to word (MemAddr offset) of the line, and MemAddr increments by 1.
  - On the final ack (offset = LINE_WORDS-1):
    - MemReq drops the next cycle.
    - Tag is written and the valid bit is set.
    - Go to RESP.
  - Words are always filled from offset 0; there is no critical-word-first.
  - ReqReady = 0 throughout.
- RESP:
  - RespValid = 1 with the requested word, unless killed.
  - ReqReady = 0; return to IDLE.
  - Miss latency = LINE_WORDS acks + 2 cycles.
- Flush:
  - Sets a kill flag for the outstanding request, which suppresses its RespValid.
  - In LOOKUP a hit response is suppressed in the same cycle.
  - In FILL the fill still completes and the line is installed; the memory bus cannot abort.
  - A request presented in the same cycle as Flush is the redirect target and is accepted normally, never killed.
- Invalidate:
  - In IDLE or LOOKUP, all valid bits clear at the next edge.
  - A LOOKUP hit in that same cycle still responds.
  - During FILL/RESP it is recorded as pending and applied on entry to IDLE. The just-filled line is then also invalid, but its RESP response is still delivered.
- Address wrap: a line at 0xFFFC..0xFFFF fills normally; MemAddr never increments past the line's last word.
- RespInstruct holds its last value when RespValid = 0.

Decomposition:
- Package fetch_icache_pkg holds:
  - the state enum (IDLE, LOOKUP, FILL, RESP);
  - the ADDR_W = 16 and DATA_W = 16 constants;
  - functions computing the tag, index and offset fields.
- One sub-module, fetch_icache_array:
  - data storage NUM_LINES x LINE_WORDS x 16, plus tag storage and a valid vector;
  - word write port, tag/valid write, global valid clear;
  - combinational read plus a hit output.
- The FSM, counters and kill/pending flags live in the top module.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request 0x0005 with mem words at 0x0004..0x0007 = 0xA004..0xA007, one-cycle ack latency.
  - Required: MemReq with addresses 0x0004..0x0007; RespValid with 0xA005 LINE_WORDS+2 cycles after acceptance.
- Hit streaming:
  - Stimulus: then back-to-back requests 0x0004, 0x0006, 0x0007.
  - Required: three consecutive RespValid cycles with 0xA004, 0xA006, 0xA007; MemReq stays 0.
- Conflict miss:
  - Stimulus: request 0x0045, same index with a different tag.
  - Required: refill from 0x0044. A following request to 0x0005 misses again.
- Flush during fill:
  - Stimulus: miss on 0x0100, then Flush at the second ack.
  - Required: no RespValid for 0x0100. A later request to 0x0101 hits with 1-cycle latency.
- Invalidate during fill:
  - Stimulus: Invalidate asserted mid-fill.
  - Required: the fill's response is delivered. Next requests to both the filled line and 0x0004 miss.
- Reset mid-fill:
  - Stimulus: rst low during FILL.
  - Required: MemReq = 0 and RespValid = 0 next cycle; ReqReady = 1 after release; the original address misses again.
